// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM arbiter slice.
//   ADDR_W / DATA_W : SRAM geometry (16 words x 8 bits)
//   req_id_e        : requester identity (REQ_A = 0, REQ_B = 1)
//   cmd_t           : packed command {we, addr, wdata}
//   resp_t          : pending read response {valid, id}
//   sat_inc8        : saturating 8-bit increment for the optional perf counters
package sram_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } resp_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles both requester command ports and the SRAM pins.
//   Requester A/B: req, we, addr, wdata (to arbiter); gnt, rvalid (from arbiter)
//   rdata  : shared read data, qualified by a_rvalid / b_rvalid
//   mem_*  : SRAM en/we/addr/din (from arbiter), dout (from SRAM)
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus the SRAM macro)
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_dout,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_dout,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req_i  : request vector, bit 0 = A, bit 1 = B
//   last_i : 1 when B won the most recent grant
//   gnt_o  : one-hot grant (or zero when nothing requests)
// A lone requester always wins; on a conflict the port that did not win last
// time is chosen.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = req_i[0] & (~req_i[1] |  last_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16x8 synchronous SRAM between requesters A and B.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : sram_arbiter_if.slave (requester ports + SRAM pins)
//   a_cnt, b_cnt, conflict_cnt : saturating 8-bit grant/conflict counters,
//              present only when SRAM_ARB_PERF_EN is defined
// Grants are combinational from req; the SRAM pins mux from the winning
// port and are zero when idle. Read data is the SRAM's registered dout,
// steered by a one-entry pending-response register.
module sram_arbiter
  import sram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sram_arbiter_if.slave        bus
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [7:0]           a_cnt,
  output logic [7:0]           b_cnt,
  output logic [7:0]           conflict_cnt
`endif
);

  logic [1:0] req_vec;
  logic [1:0] pick;
  logic [1:0] gnt;
  logic       last_b_q, last_b_d;
  resp_t      resp_q, resp_d;
  cmd_t       a_cmd, b_cmd, sel_cmd;

  assign req_vec = {bus.b_req, bus.a_req};
  assign a_cmd   = '{we: bus.a_we, addr: bus.a_addr, wdata: bus.a_wdata};
  assign b_cmd   = '{we: bus.b_we, addr: bus.b_addr, wdata: bus.b_wdata};

  rr_arb2 u_rr_arb2 (
    .req_i  (req_vec),
    .last_i (last_b_q),
    .gnt_o  (pick)
  );

  // Nothing may reach the SRAM while reset is asserted.
  assign gnt = rst ? 2'b00 : pick;

  always_comb begin
    sel_cmd  = '0;
    last_b_d = last_b_q;
    if (gnt[0]) begin
      sel_cmd = a_cmd;
    end else if (gnt[1]) begin
      sel_cmd = b_cmd;
    end
    if (|gnt) begin
      last_b_d = gnt[1];
    end
    resp_d.valid = (|gnt) & ~sel_cmd.we;
    resp_d.id    = gnt[1] ? REQ_B : REQ_A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
      resp_q   <= '{valid: 1'b0, id: REQ_A};
    end else begin
      last_b_q <= last_b_d;
      resp_q   <= resp_d;
    end
  end

  assign bus.a_gnt    = gnt[0];
  assign bus.b_gnt    = gnt[1];
  assign bus.mem_en   = |gnt;
  assign bus.mem_we   = sel_cmd.we;
  assign bus.mem_addr = sel_cmd.addr;
  assign bus.mem_din  = sel_cmd.wdata;
  assign bus.rdata    = bus.mem_dout;

  // Gating with rst drops a read that was granted just before reset: its
  // response register has not been cleared yet during the reset cycle.
  assign bus.a_rvalid = resp_q.valid & (resp_q.id == REQ_A) & ~rst;
  assign bus.b_rvalid = resp_q.valid & (resp_q.id == REQ_B) & ~rst;

`ifdef SRAM_ARB_PERF_EN
  logic [7:0] a_cnt_q, b_cnt_q, conflict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q        <= 8'd0;
      b_cnt_q        <= 8'd0;
      conflict_cnt_q <= 8'd0;
    end else begin
      if (gnt[0])   a_cnt_q        <= sat_inc8(a_cnt_q);
      if (gnt[1])   b_cnt_q        <= sat_inc8(b_cnt_q);
      if (&req_vec) conflict_cnt_q <= sat_inc8(conflict_cnt_q);
    end
  end

  assign a_cnt        = a_cnt_q;
  assign b_cnt        = b_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a behavioural
// 16x8 synchronous SRAM (registered dout) hanging off the mem_* pins.
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge. Define SRAM_ARB_PERF_EN to also exercise the counters.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [DATA_W-1:0] sram [16];
  logic [DATA_W-1:0] exp_mem [16];
  logic [DATA_W-1:0] dout_r;

  sram_arbiter_if bus ();

`ifdef SRAM_ARB_PERF_EN
  logic [7:0] a_cnt, b_cnt, conflict_cnt;
`endif

  sram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SRAM_ARB_PERF_EN
    ,
    .a_cnt        (a_cnt),
    .b_cnt        (b_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: one access per enabled cycle, dout registered.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_din;
      dout_r <= sram[bus.mem_addr];
    end
  end
  assign bus.mem_dout = dout_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_check();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  logic [17:0] outs;
  assign outs = {bus.a_gnt, bus.b_gnt, bus.mem_en, bus.mem_we, bus.mem_addr,
                 bus.mem_din, bus.a_rvalid, bus.b_rvalid};

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();

    // Requests during reset must not be granted.
    cyc_begin();
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    cyc_check();
    chk("rst_outputs", 32'(outs), 32'd0);

    // Release reset, then 5 idle cycles with everything at zero.
    for (int i = 0; i < 5; i++) begin
      cyc_begin();
      rst = 1'b0;
      idle_inputs();
      cyc_check();
      chk($sformatf("idle_outputs_%0d", i), 32'(outs), 32'd0);
    end

    // First dual request after reset goes to A; B follows next cycle.
    cyc_begin();
    bus.a_req = 1'b1; bus.a_addr = 4'd1;
    bus.b_req = 1'b1; bus.b_addr = 4'd2;
    cyc_check();
    chk("first_conflict_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'b10);
    cyc_begin();
    bus.a_req = 1'b0;
    cyc_check();
    chk("loser_next_gnt", 32'({bus.a_gnt, bus.b_gnt}), 32'b01);
    chk("first_a_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'b10);
    cyc_begin();
    bus.b_req = 1'b0;
    cyc_check();
    chk("first_b_rvalid", 32'({bus.a_rvalid, bus.b_rvalid, bus.mem_en}), 32'b010);

    // A fills the whole SRAM back-to-back.
    for (int i = 0; i < 16; i++) begin
      cyc_begin();
      exp_mem[i]   = 8'(i * 37 + 11);
      bus.a_req    = 1'b1;
      bus.a_we     = 1'b1;
      bus.a_addr   = 4'(i);
      bus.a_wdata  = exp_mem[i];
      cyc_check();
      chk($sformatf("fill_gnt_%0d", i),
          32'({bus.a_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din}),
          32'({1'b1, 1'b1, 1'b1, 4'(i), exp_mem[i]}));
    end

    // A writes 0x5A to addr 3; B reads it back the next cycle.
    cyc_begin();
    bus.a_addr = 4'd3; bus.a_wdata = 8'h5A; exp_mem[3] = 8'h5A;
    cyc_check();
    chk("w5a_pins", 32'({bus.a_gnt, bus.mem_we, bus.mem_addr, bus.mem_din}),
        32'({1'b1, 1'b1, 4'd3, 8'h5A}));
    cyc_begin();
    idle_inputs();
    bus.b_req = 1'b1; bus.b_addr = 4'd3;
    cyc_check();
    chk("r3_gnt", 32'({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.mem_we}), 32'b0100);
    cyc_begin();
    bus.b_req = 1'b0;
    cyc_check();
    chk("r3_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'b01);
    chk("r3_rdata", 32'(bus.rdata), 32'h5A);

    // Continuous dual reads: B won last, so A, B, A, ... ; A reads 5, B reads 9.
    for (int k = 0; k < 9; k++) begin
      cyc_begin();
      bus.a_req = (k < 8); bus.a_we = 1'b0; bus.a_addr = 4'd5;
      bus.b_req = (k < 8); bus.b_we = 1'b0; bus.b_addr = 4'd9;
      cyc_check();
      if (k < 8) begin
        chk($sformatf("alt_gnt_%0d", k), 32'({bus.a_gnt, bus.b_gnt}),
            (k % 2 == 0) ? 32'b10 : 32'b01);
      end
      if (k > 0) begin
        chk($sformatf("alt_rvalid_%0d", k), 32'({bus.a_rvalid, bus.b_rvalid}),
            (k % 2 == 1) ? 32'b10 : 32'b01);
        chk($sformatf("alt_rdata_%0d", k), 32'(bus.rdata),
            32'((k % 2 == 1) ? exp_mem[5] : exp_mem[9]));
      end
    end

    // B alone reads 0..15 back-to-back; data returns in order.
    for (int i = 0; i < 17; i++) begin
      cyc_begin();
      bus.b_req  = (i < 16);
      bus.b_addr = 4'(i);
      cyc_check();
      if (i < 16) begin
        chk($sformatf("sweep_gnt_%0d", i), 32'({bus.b_gnt, bus.mem_addr}),
            32'({1'b1, 4'(i)}));
      end
      if (i > 0) begin
        chk($sformatf("sweep_rd_%0d", i - 1), 32'({bus.b_rvalid, bus.a_rvalid, bus.rdata}),
            32'({1'b1, 1'b0, exp_mem[i-1]}));
      end
    end

    // A read granted, then reset: response suppressed, A wins after reset.
    cyc_begin();
    idle_inputs();
    bus.a_req = 1'b1; bus.a_addr = 4'd3;
    cyc_check();
    chk("pre_rst_gnt", 32'(bus.a_gnt), 32'd1);
    cyc_begin();
    idle_inputs();
    rst = 1'b1;
    cyc_check();
    chk("rst_drops_rvalid", 32'({bus.a_rvalid, bus.b_rvalid, bus.mem_en}), 32'b000);
    cyc_begin();
    rst = 1'b0;
    bus.a_req = 1'b1; bus.a_addr = 4'd7;
    bus.b_req = 1'b1; bus.b_addr = 4'd8;
    cyc_check();
    chk("post_rst_conflict", 32'({bus.a_gnt, bus.b_gnt}), 32'b10);
    cyc_begin();
    idle_inputs();
    cyc_check();
    chk("post_rst_rdata", 32'({bus.a_rvalid, bus.b_rvalid, bus.rdata}),
        32'({1'b1, 1'b0, exp_mem[7]}));

`ifdef SRAM_ARB_PERF_EN
    cyc_begin();
    rst = 1'b1;
    cyc_begin();
    rst = 1'b0;
    cyc_check();
    chk("perf_clear", 32'({a_cnt, b_cnt, conflict_cnt}), 32'd0);
    // 3 conflicts (A, B, A) then 300 A-only grants.
    for (int i = 0; i < 303; i++) begin
      cyc_begin();
      bus.a_req = 1'b1;
      bus.b_req = (i < 3);
      cyc_check();
    end
    cyc_begin();
    idle_inputs();
    cyc_check();
    chk("perf_a_cnt", 32'(a_cnt), 32'd255);
    chk("perf_b_cnt", 32'(b_cnt), 32'd1);
    chk("perf_conflict_cnt", 32'(conflict_cnt), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter that shares the single-port 16x8 synchronous SRAM between two requesters (A and B). Each requester sees a simple req/gnt command port plus a read-response valid. The arbiter drives the SRAM's clk/en/we/addr/din pins and routes its registered dout back to whichever requester issued the read. It sits directly in front of the SRAM macro and is the only master on its pins.

## Interface
- ADDR_W, 4, SRAM address width (16 words)
- DATA_W, 8, SRAM data width
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- a_req, b_req  in  1  access request; command fields held stable while req && !gnt
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  ADDR_W  word address
- a_wdata, b_wdata  in  DATA_W  write data
- a_gnt, b_gnt  out  1  command accepted this cycle (combinational)
- a_rvalid, b_rvalid  out  1  read data valid on rdata (registered)
- rdata  out  DATA_W  shared read data, meaningful only with an rvalid
- mem_en, mem_we  out  1  to SRAM en/we
- mem_addr  out  ADDR_W  to SRAM addr
- mem_din  out  DATA_W  to SRAM din
- mem_dout  in  DATA_W  from SRAM dout

## Operation
- Each cycle, at most one request is granted; mem_en = a_gnt | b_gnt, and mem_we/addr/din mux from the granted port.
- Only one requester active: it is granted every cycle it requests. There are no bubbles, and back-to-back accesses are allowed.
- Both requesting: the winner is the port not granted most recently (register last_b; 1 = B won last).
- last_b updates only on a grant. With no request it holds.
- Loser keeps req asserted and is granted the next cycle (worst-case wait is 1 cycle).
- Dropping req before gnt is legal and has no side effect.
- Read: a pending-response register {valid, id} captures the grant at the edge. In the next cycle the matching rvalid = 1 and rdata = mem_dout.
- Write: gnt is the only completion. No rvalid.
- A write to address X granted in cycle N is visible to a read of X granted in cycle N+1 or later.
- Reset:
  - gnt and mem_en are forced 0 while rst = 1.
  - a_rvalid/b_rvalid are 0.
  - last_b = 1, so A has priority first.
  - A read granted in the cycle before rst is discarded; its rvalid is suppressed.
  - The arbiter does not touch SRAM contents.

## Timing
- Grant latency: 0 cycles (gnt in the same cycle as req if it wins).
- Read latency: rvalid exactly 1 cycle after gnt. Sustained throughput is 1 access/cycle in total.
- Outputs at reset: a_gnt = b_gnt = 0, mem_en = mem_we = 0, mem_addr = 0, mem_din = 0, a_rvalid = b_rvalid = 0, rdata = mem_dout (don't-care).
- mem_addr/mem_din are 0 when idle, not held.
- Combinational path: req → gnt → mem_* only. There is no path from mem_dout to gnt.

## Configuration
- SRAM_ARB_PERF_EN defined:
  - Adds outputs a_cnt and b_cnt (8 bits, saturating at 255), each counting grants to its port.
  - Adds output conflict_cnt (8 bits, saturating), counting cycles with both requests asserted.
  - All three counters clear on rst.
- SRAM_ARB_PERF_EN undefined: these ports and registers do not exist. Arbitration behaviour is identical either way.

## Structure
- Package sram_arb_pkg holds:
  - ADDR_W/DATA_W defaults.
  - Requester-id enum (REQ_A = 0, REQ_B = 1).
  - Packed command struct {we, addr, wdata}.
  - Response struct {valid, id}.
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: one-hot gnt[1:0].
  - The last_b register stays in sram_arbiter.

## Test plan
- Reset then idle: all outputs are 0 for 5 cycles; first dual request grants A.
- A writes 0x5A to addr 3, then B reads addr 3 next cycle: b_gnt = 1, then b_rvalid = 1 with rdata = 0x5A one cycle later; a_rvalid stays 0.
- A and B both read continuously for 8 cycles: grants alternate A, B, A, …, and each rvalid follows its gnt by exactly 1 cycle.
- Only B reads addr 0..15 back-to-back: b_gnt = 1 for 16 consecutive cycles and data returns in order.
- A read is granted in cycle N with rst = 1 in N+1: no rvalid, and after reset A wins the first conflict.
- With SRAM_ARB_PERF_EN, 300 A-only grants: a_cnt = 255 and b_cnt = 0. conflict_cnt equals the number of dual-request cycles.
